// File: rtl/instr_mem_loader.sv
// instr_mem_loader: encodes symbolic instruction descriptors into MIPS words and writes them
// sequentially into instruction memory from word 0 while holding the core.
// Latency: a write appears one cycle after each handshake; throughput is one word per 2 cycles.
// Backpressure: in_ready is high only in LOAD; optional checksum port enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              illegal_err,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              ovf_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SLTI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_J    = 4'd10;
  localparam logic [3:0] OP_JAL  = 4'd11;
  localparam logic [3:0] OP_JR   = 4'd12;

  // Address of the final writable word; a write here without last ends the load as overflow.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              last_q;
  logic              enc_legal;
  logic [31:0]       enc_word;

  // Encode the presented descriptor; ops 13-15 are flagged illegal and never written.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'h0;
    case (in_op)
      OP_ADD:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      OP_SUB:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      OP_AND:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      OP_OR:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      OP_SLT:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      OP_JR:   enc_word = {6'b000000, in_rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      OP_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm};
      OP_SLTI: enc_word = {6'b001010, in_rs, in_rt, in_imm};
      OP_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
      OP_SW:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
      OP_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
      OP_J:    enc_word = {6'b000010, in_target};
      OP_JAL:  enc_word = {6'b000011, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // Load sequencer; every output is a register updated alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
      cpu_hold    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal_err <= 1'b0;
      ovf_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum    <= 32'h0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD;
            ptr         <= '0;
            illegal_err <= 1'b0;
            ovf_err     <= 1'b0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b1;
            in_ready    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= 32'h0;
`endif
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (enc_legal) begin
              mem_wdata <= enc_word;
              mem_addr  <= ptr;
              last_q    <= in_last;
              mem_we    <= 1'b1;
              in_ready  <= 1'b0;
              state     <= ST_WRITE;
            end else begin
              illegal_err <= 1'b1;
              if (in_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                state    <= ST_DONE;
              end
            end
          end
        end
        ST_WRITE: begin
          mem_we <= 1'b0;
          ptr    <= ptr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          checksum <= checksum ^ mem_wdata;
`endif
          if (last_q || (ptr == LAST_ADDR)) begin
            done  <= 1'b1;
            state <= ST_DONE;
            if (!last_q) begin
              ovf_err <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        default: begin
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: drives directed and random descriptor programs into instr_mem_loader
// and compares observed memory writes and status flags against a program-level reference model.
// Uses a small instance (DEPTH=4) so that overflow is reached quickly.
module tb_instr_mem_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } desc_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [4:0]        in_rs = '0;
  logic [4:0]        in_rt = '0;
  logic [4:0]        in_rd = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              illegal_err;
  logic              ovf_err;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .illegal_err(illegal_err),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  desc_t       prog[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt = 0;
  logic [31:0] got_cks = '0;

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_ill;
  bit          exp_ovf;
  int          exp_acc;
  bit          exp_end;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observe the memory port and status pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(mem_wdata);
    end
    if (done) begin
      done_cnt++;
`ifdef LOADER_CHECKSUM_EN
      got_cks = checksum;
`endif
    end
  end

  // Reference encoding: bit 32 is the legal flag, bits 31:0 the instruction word.
  function automatic logic [32:0] ref_enc(input desc_t d);
    logic [31:0] r;
    logic [31:0] it;
    logic [31:0] w;
    r  = (32'(d.rs) << 21) | (32'(d.rt) << 16) | (32'(d.rd) << 11);
    it = (32'(d.rs) << 21) | (32'(d.rt) << 16) | 32'(d.imm);
    w  = 32'h0;
    case (int'(d.op))
      0:  w = r | 32'h20;
      1:  w = r | 32'h22;
      2:  w = r | 32'h24;
      3:  w = r | 32'h25;
      4:  w = r | 32'h2A;
      12: w = (32'(d.rs) << 21) | 32'h08;
      5:  w = (32'h08 << 26) | it;
      6:  w = (32'h0A << 26) | it;
      7:  w = (32'h23 << 26) | it;
      8:  w = (32'h2B << 26) | it;
      9:  w = (32'h04 << 26) | it;
      10: w = (32'h02 << 26) | 32'(d.target);
      11: w = (32'h03 << 26) | 32'(d.target);
      default: return {1'b0, 32'h0};
    endcase
    return {1'b1, w};
  endfunction

  // Program-level model: walk descriptors, filling words until last or memory is full.
  task automatic model();
    int p;
    logic [32:0] e;
    exp_addr.delete(); exp_data.delete();
    exp_ill = 0; exp_ovf = 0; exp_acc = 0; exp_end = 0; p = 0;
    foreach (prog[i]) begin
      if (exp_end) break;
      exp_acc++;
      e = ref_enc(prog[i]);
      if (!e[32]) begin
        exp_ill = 1;
        if (prog[i].last) exp_end = 1;
      end else begin
        exp_addr.push_back(p);
        exp_data.push_back(e[31:0]);
        if (prog[i].last) exp_end = 1;
        else if (p == DEPTH - 1) begin exp_ovf = 1; exp_end = 1; end
        p++;
      end
    end
  endtask

  task automatic clear_mon();
    got_addr.delete(); got_data.delete(); done_cnt = 0; got_cks = '0;
  endtask

  task automatic drive_desc(input desc_t d);
    in_op = d.op; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd;
    in_imm = d.imm; in_target = d.target; in_last = d.last; in_valid = 1'b1;
  endtask

  // Feed the program; poke_at >= 0 raises start while descriptor poke_at is offered.
  task automatic run_prog(input string name, input int poke_at);
    int cnt;
    int acc;
    bit ended;
    logic [32:0] e;
    logic [31:0] cks;
    clear_mon();
    model();
    acc = 0; ended = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ":busy_on"}, 32'(busy), 32'd1);
    check({name, ":hold_on"}, 32'(cpu_hold), 32'd1);
    foreach (prog[i]) begin
      if (ended) break;
      drive_desc(prog[i]);
      if (i == poke_at) start = 1'b1;
      cnt = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        if (!busy) begin ended = 1; break; end
        cnt++;
        if (cnt > 20) begin
          check({name, ":rdy_timeout"}, 32'd0, 32'd1);
          ended = 1;
          break;
        end
      end
      if (ended) start = 1'b0;
      else begin
        @(posedge clk); #1;
        start = 1'b0;
        acc++;
        e = ref_enc(prog[i]);
        check({name, ":we_lat"}, 32'(mem_we), 32'(e[32]));
      end
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin @(negedge clk); cnt++; end
    check({name, ":end_timeout"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, ":accepted"}, 32'(acc), 32'(exp_acc));
    check({name, ":nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    cks = '0;
    foreach (exp_addr[i]) begin
      cks ^= exp_data[i];
      if (i < got_addr.size()) begin
        check({name, ":addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
        check({name, ":wdata"}, got_data[i], exp_data[i]);
      end
    end
    if (exp_data.size() > 0) check({name, ":wdata_hold"}, mem_wdata, exp_data[exp_data.size()-1]);
    check({name, ":illegal_err"}, 32'(illegal_err), 32'(exp_ill));
    check({name, ":ovf_err"}, 32'(ovf_err), 32'(exp_ovf));
    check({name, ":done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, ":hold_off"}, 32'(cpu_hold), 32'd0);
    check({name, ":in_ready_idle"}, 32'(in_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check({name, ":checksum"}, got_cks, cks);
`endif
  endtask

  function automatic desc_t mk(input int op, input int rs, input int rt, input int rd,
                               input int imm, input int tgt, input bit last);
    desc_t d;
    d.op = 4'(op); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd);
    d.imm = 16'(imm); d.target = 26'(tgt); d.last = last;
    return d;
  endfunction

  function automatic desc_t rnd_desc();
    desc_t d;
    d.op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
    d.rs = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom);
    d.imm = 16'($urandom); d.target = 26'($urandom); d.last = 1'b0;
    return d;
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst:mem_we", 32'(mem_we), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd0);
    check("rst:cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst:errs", {30'd0, illegal_err, ovf_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed program with fixed expected words.
    prog.delete();
    prog.push_back(mk(0, 1, 2, 3, 0, 0, 0));
    prog.push_back(mk(7, 5, 4, 0, 16'h0008, 0, 0));
    prog.push_back(mk(9, 1, 2, 0, 16'hFFFF, 0, 0));
    prog.push_back(mk(10, 0, 0, 0, 0, 26'h10, 1));
    run_prog("basic", -1);
    check("basic:w0", got_data.size() > 0 ? got_data[0] : 32'hx, 32'h00221820);
    check("basic:w1", got_data.size() > 1 ? got_data[1] : 32'hx, 32'h8CA40008);
    check("basic:w2", got_data.size() > 2 ? got_data[2] : 32'hx, 32'h1022FFFF);
    check("basic:w3", got_data.size() > 3 ? got_data[3] : 32'hx, 32'h08000010);

    // Illegal op mid-stream does not consume an address.
    prog.delete();
    prog.push_back(mk(0, 1, 2, 3, 0, 0, 0));
    prog.push_back(mk(14, 7, 7, 7, 0, 0, 0));
    prog.push_back(mk(5, 2, 3, 0, 16'h1234, 0, 1));
    run_prog("illegal", -1);
    check("illegal:addr1", got_addr.size() > 1 ? 32'(got_addr[1]) : 32'hx, 32'd1);
    check("illegal:w1", got_data.size() > 1 ? got_data[1] : 32'hx, 32'h20431234);

    // Overflow: five descriptors, none last.
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(mk(i, i, i + 1, i + 2, 0, 0, 0));
    run_prog("ovf", -1);

    // Start pulsed mid-load after an illegal op must be ignored.
    prog.delete();
    prog.push_back(mk(15, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(3, 4, 5, 6, 0, 0, 0));
    prog.push_back(mk(12, 31, 9, 9, 0, 0, 0));
    prog.push_back(mk(11, 0, 0, 0, 26'h3FFFFFF, 0, 1));
    run_prog("restart_ign", 2);

    // Reset during WRITE aborts the load immediately.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_desc(mk(1, 1, 1, 1, 0, 0, 0));
    @(negedge clk);
    check("rstw:ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstw:in_write", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw:mem_we", 32'(mem_we), 32'd0);
    check("rstw:outs", {25'd0, in_ready, busy, cpu_hold, done, illegal_err, ovf_err, mem_we}, 32'd0);
    check("rstw:data", mem_wdata | 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rstw:still_idle", 32'(busy), 32'd0);
    prog.delete();
    prog.push_back(mk(2, 3, 4, 5, 0, 0, 0));
    prog.push_back(mk(6, 8, 9, 0, 16'h8000, 0, 1));
    run_prog("after_rst", -1);

    // Random programs; unterminated ones get last forced on the final descriptor.
    for (int t = 0; t < 40; t++) begin
      prog.delete();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) prog.push_back(rnd_desc());
      if ($urandom_range(0, 2) != 0) prog[n-1].last = 1'b1;
      model();
      if (!exp_end) prog[n-1].last = 1'b1;
      run_prog($sformatf("rnd%0d", t), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Encoder/writer side of the instruction-decode path.
- Accepts symbolic instruction descriptors over a valid/ready stream, encodes each into a 32-bit MIPS word, and writes it sequentially into instruction memory from address 0.
- Holds the single-cycle core (cpu_hold) while a program load is in progress.
- Emits exactly the encodings the main controller and ALU controller decode.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of writable words; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  loader can accept a descriptor.
- in_op  input  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 slti, 7 lw, 8 sw, 9 beq, 10 j, 11 jal, 12 jr; 13-15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate/offset (I-type).
- in_target  input  26  jump target (j/jal).
- in_last  input  1  marks the final descriptor of the program.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  encoded instruction.
- cpu_hold  output  1  core held while high.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse at load completion.
- illegal_err  output  1  sticky; an illegal op was received.
- ovf_err  output  1  sticky; memory filled before in_last.

Behaviour:
- Reset: all outputs 0; ptr=0; state IDLE. Reset mid-load aborts immediately; no further writes.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start → LOAD; ptr←0; illegal_err, ovf_err cleared; cpu_hold←1.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Handshake occurs when in_valid & in_ready.
  - Legal op: register encoded word into mem_wdata, mem_addr←ptr, capture in_last → WRITE.
  - Illegal op: no write, illegal_err←1; → DONE if in_last, else stay in LOAD.
- WRITE:
  - in_ready=0; mem_we=1 for exactly this cycle; ptr←ptr+1.
  - → DONE if captured last or ptr==DEPTH-1, else LOAD.
  - ptr==DEPTH-1 without last sets ovf_err.
- DONE: done=1 for one cycle; cpu_hold←0; → IDLE.
- Throughput: one word per 2 cycles. Write appears 1 cycle after handshake.
- busy=1 in LOAD, WRITE, DONE.
- Encoding:
  - R-type: op=000000, shamt=0, fields {op,rs,rt,rd,shamt,funct}. funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000 (jr: rt=rd=0).
  - I-type: {opc,rs,rt,imm}. opc: addi 001000, slti 001010, lw 100011, sw 101011, beq 000100.
  - J-type: {opc,target}. opc: j 000010, jal 000011.
- mem_wdata and mem_addr hold their last values outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], reset 0, cleared on start.
  - XOR-accumulated with mem_wdata on every mem_we cycle.
  - Valid when done pulses; held until next start.
- Undefined: no checksum port or logic; all other behaviour identical.

Test Plan:
- start; add rs=1 rt=2 rd=3 (last=0) → mem_we at addr 0, wdata 0x00221820; busy=1; cpu_hold=1.
- Continue: lw rs=5 rt=4 imm=0x0008 → addr 1, wdata 0x8CA40008; beq rs=1 rt=2 imm=0xFFFF → addr 2, 0x1022FFFF; j target=0x10 with last=1 → addr 3, 0x08000010; done pulse; cpu_hold=0. With LOADER_CHECKSUM_EN, checksum=XOR of the four words.
- in_op=14 mid-stream → no mem_we, illegal_err=1, following legal op written at unchanged ptr.
- DEPTH=4, feed 5 descriptors, none last → writes at addrs 0-3, ovf_err=1, done after 4th write, 5th descriptor not accepted (in_ready=0).
- Assert rst during WRITE → mem_we=0 next cycle, all outputs 0, state IDLE; subsequent start reloads from addr 0.
- start pulsed while busy → ignored; ptr and errors unchanged.
